// File: rtl/qeip_reset_sequencer.sv
// Reset sequencer: qualifies PLL lock, then releases the peripheral domain
// followed by the core domain; tracks the last reset cause and lock losses.
module qeip_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_STABLE    = 16,
    parameter int HOLD_CYCLES    = 32,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rstnn,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       rstnn_periph,
    output logic       rstnn_core,
    output logic       ready,
    output logic [1:0] reset_cause,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_A   = (LOCK_STABLE > HOLD_CYCLES) ? LOCK_STABLE : HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_A > STAGGER_CYCLES) ? MAX_A : STAGGER_CYCLES;
    // The counter only ever reaches MAX_CNT-1 before it is cleared.
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);

    localparam logic [2:0] ST_ASSERT     = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] ST_HOLD       = 3'd2;
    localparam logic [2:0] ST_REL_PERIPH = 3'd3;
    localparam logic [2:0] ST_RUN        = 3'd4;

    localparam logic [1:0] CAUSE_EXT  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;

    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   rstnn_s;
    logic                   locked_s;

    // NOTE: reset asserts asynchronously but releases only after SYNC_STAGES
    // clk edges, so the rest of the block never sees a metastable release.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign rstnn_s  = rst_sync[SYNC_STAGES-1];
    assign locked_s = lock_sync[SYNC_STAGES-1];

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             periph_n, core_n, ready_n;
    logic [1:0]       cause_n;
    logic [7:0]       llc_n;

    // NOTE: every next-state variable gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        periph_n = rstnn_periph;
        core_n   = rstnn_core;
        ready_n  = ready;
        cause_n  = reset_cause;
        llc_n    = lock_loss_count;

        case (state)
            ST_ASSERT: begin
                periph_n = 1'b0;
                core_n   = 1'b0;
                ready_n  = 1'b0;
                cnt_n    = '0;
                state_n  = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!locked_s) begin
                    cnt_n = '0;
                end else if (cnt == LOCK_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_HOLD;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n    = '0;
                    periph_n = 1'b1;
                    state_n  = ST_REL_PERIPH;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_REL_PERIPH: begin
                if (cnt == STAG_LAST) begin
                    cnt_n   = '0;
                    core_n  = 1'b1;
                    ready_n = 1'b1;
                    state_n = ST_RUN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_reset_req) begin
                    periph_n = 1'b0;
                    core_n   = 1'b0;
                    ready_n  = 1'b0;
                    cause_n  = CAUSE_SW;
                    state_n  = ST_ASSERT;
                end
            end
            default: begin
                periph_n = 1'b0;
                core_n   = 1'b0;
                ready_n  = 1'b0;
                cnt_n    = '0;
                state_n  = ST_ASSERT;
            end
        endcase

        // Lock loss overrides whatever the state logic above decided,
        // including a simultaneous software request in RUN.
        if (!locked_s && (state == ST_HOLD || state == ST_REL_PERIPH || state == ST_RUN)) begin
            periph_n = 1'b0;
            core_n   = 1'b0;
            ready_n  = 1'b0;
            cnt_n    = '0;
            cause_n  = CAUSE_LOCK;
            llc_n    = (lock_loss_count == 8'hFF) ? lock_loss_count : lock_loss_count + 8'd1;
            state_n  = ST_ASSERT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rstnn_s) begin
        if (!rstnn_s) begin
            state           <= ST_ASSERT;
            cnt             <= '0;
            rstnn_periph    <= 1'b0;
            rstnn_core      <= 1'b0;
            ready           <= 1'b0;
            reset_cause     <= CAUSE_EXT;
            lock_loss_count <= 8'd0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            rstnn_periph    <= periph_n;
            rstnn_core      <= core_n;
            ready           <= ready_n;
            reset_cause     <= cause_n;
            lock_loss_count <= llc_n;
        end
    end

endmodule

// File: tb/tb_qeip_reset_sequencer.sv
// Scoreboard bench: stimulus pushes the expected output tuple and the cycle it
// must appear on; a negedge monitor pops and compares on every output change.
module tb_qeip_reset_sequencer;

    logic       clk;
    logic       rstnn;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       rstnn_periph;
    logic       rstnn_core;
    logic       ready;
    logic [1:0] reset_cause;
    logic [7:0] lock_loss_count;

    qeip_reset_sequencer #(
        .SYNC_STAGES   (2),
        .LOCK_STABLE   (4),
        .HOLD_CYCLES   (8),
        .STAGGER_CYCLES(2)
    ) dut (
        .clk            (clk),
        .rstnn          (rstnn),
        .pll_locked     (pll_locked),
        .sw_reset_req   (sw_reset_req),
        .rstnn_periph   (rstnn_periph),
        .rstnn_core     (rstnn_core),
        .ready          (ready),
        .reset_cause    (reset_cause),
        .lock_loss_count(lock_loss_count)
    );

    typedef struct {
        logic [12:0] val;
        int          at;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [12:0] tup(input logic p, input logic c, input logic r,
                                        input logic [1:0] cause, input logic [7:0] cnt);
        return {p, c, r, cause, cnt};
    endfunction

    task automatic expect_at(input logic [12:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    // Monitor: compares every change of the registered output tuple.
    initial begin
        logic [12:0] prev, cur;
        bit          have_prev;
        exp_t        e;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            cur = {rstnn_periph, rstnn_core, ready, reset_cause, lock_loss_count};
            if (have_prev && cur !== prev) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change: got %0h was %0h at cycle %0d", cur, prev, cyc);
                end else begin
                    e = q.pop_front();
                    check("mon_value", 32'(cur), 32'(e.val));
                    check("mon_cycle", cyc, e.at);
                    check("order_core_after_periph", 32'(cur[11] & ~cur[12]), 32'd0);
                end
            end
            prev      = cur;
            have_prev = 1'b1;
        end
    end

    initial begin
        int k, r, b;
        logic [7:0] llc;

        rstnn        = 1'b1;
        pll_locked   = 1'b1;
        sw_reset_req = 1'b0;
        #1 rstnn = 1'b0;

        // Power-up with lock held high.
        tick(3);
        check("rst_periph", 32'(rstnn_periph), 32'd0);
        check("rst_core", 32'(rstnn_core), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_cause", 32'(reset_cause), 32'd0);
        check("rst_llc", 32'(lock_loss_count), 32'd0);
        rstnn = 1'b1;
        r = cyc;
        expect_at(tup(1, 0, 0, 2'd0, 8'd0), r + 15);
        expect_at(tup(1, 1, 1, 2'd0, 8'd0), r + 17);
        wait_until(r + 20);

        // Software reset in RUN, then a software pulse during HOLD is ignored.
        k = cyc;
        sw_reset_req = 1'b1;
        expect_at(tup(0, 0, 0, 2'd2, 8'd0), k + 1);
        expect_at(tup(1, 0, 0, 2'd2, 8'd0), k + 14);
        expect_at(tup(1, 1, 1, 2'd2, 8'd0), k + 16);
        tick(1);
        sw_reset_req = 1'b0;
        wait_until(k + 7);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        wait_until(k + 20);

        // Lock loss in RUN, then lock returns and the full sequence repeats.
        k = cyc;
        pll_locked = 1'b0;
        expect_at(tup(0, 0, 0, 2'd1, 8'd1), k + 3);
        wait_until(k + 5);
        pll_locked = 1'b1;
        expect_at(tup(1, 0, 0, 2'd1, 8'd1), k + 19);
        expect_at(tup(1, 1, 1, 2'd1, 8'd1), k + 21);
        wait_until(k + 25);

        // Software request and lock loss in the same RUN cycle.
        k = cyc;
        pll_locked = 1'b0;
        tick(2);
        sw_reset_req = 1'b1;
        expect_at(tup(0, 0, 0, 2'd1, 8'd2), k + 3);
        tick(1);
        sw_reset_req = 1'b0;
        wait_until(k + 6);

        // 300 lock losses during HOLD; the count saturates at 255.
        llc = 8'd2;
        for (int i = 0; i < 300; i++) begin
            b = cyc;
            pll_locked = 1'b1;
            if (llc != 8'hFF) begin
                llc = llc + 8'd1;
                expect_at(tup(0, 0, 0, 2'd1, llc), b + 9);
            end
            wait_until(b + 6);
            pll_locked = 1'b0;
            wait_until(b + 12);
        end
        check("llc_saturated", 32'(lock_loss_count), 32'd255);

        // One-cycle lock glitch after three qualified cycles restarts the count.
        k = cyc;
        pll_locked = 1'b1;
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        expect_at(tup(1, 0, 0, 2'd1, 8'd255), k + 18);
        expect_at(tup(1, 1, 1, 2'd1, 8'd255), k + 20);
        wait_until(k + 24);

        // Lock loss at saturation leaves the count at 255.
        k = cyc;
        pll_locked = 1'b0;
        expect_at(tup(0, 0, 0, 2'd1, 8'd255), k + 3);
        wait_until(k + 6);

        // External reset asserted mid-HOLD clears everything asynchronously.
        b = cyc;
        pll_locked = 1'b1;
        wait_until(b + 9);
        #2;
        expect_at(tup(0, 0, 0, 2'd0, 8'd0), b + 9);
        rstnn = 1'b0;
        #1;
        check("hold_rst_cause", 32'(reset_cause), 32'd0);
        check("hold_rst_llc", 32'(lock_loss_count), 32'd0);
        check("hold_rst_periph", 32'(rstnn_periph), 32'd0);
        @(posedge clk);
        #1;
        tick(2);
        rstnn = 1'b1;
        r = cyc;
        expect_at(tup(1, 0, 0, 2'd0, 8'd0), r + 15);
        expect_at(tup(1, 1, 1, 2'd0, 8'd0), r + 17);
        wait_until(r + 20);

        // External reset asserted in RUN drops the outputs without a clock edge.
        k = cyc;
        #2;
        expect_at(tup(0, 0, 0, 2'd0, 8'd0), k);
        rstnn = 1'b0;
        #1;
        check("async_periph", 32'(rstnn_periph), 32'd0);
        check("async_core", 32'(rstnn_core), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        tick(1);
        rstnn = 1'b1;
        r = cyc;
        expect_at(tup(1, 0, 0, 2'd0, 8'd0), r + 15);
        expect_at(tup(1, 1, 1, 2'd0, 8'd0), r + 17);
        wait_until(r + 20);

        for (int i = 0; i < 40 && q.size() != 0; i++) tick(1);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qeip_reset_sequencer.md
QEIP_RESET_SEQUENCER -- requirements
Module: qeip_reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, 2, flop count of each input synchronizer (legal 2..4).
REQ-002 Parameter LOCK_STABLE, 16, consecutive cycles pll_locked must be high before release starts (legal ≥1).
REQ-003 Parameter HOLD_CYCLES, 32, cycles all domain resets stay low after lock qualifies (legal ≥1).
REQ-004 Parameter STAGGER_CYCLES, 4, cycles between peripheral and core release (legal ≥1).
REQ-005 Port clk, input, 1, system clock (clk_system of the PLL stage); the block has exactly one clock.
REQ-006 Port rstnn, input, 1, external reset; asynchronous, active-low.
REQ-007 Port pll_locked, input, 1, PLL lock indication; asynchronous to clk.
REQ-008 Port sw_reset_req, input, 1, synchronous one-cycle software reset request.
REQ-009 Port rstnn_periph, output, 1, peripheral-domain reset, active-low.
REQ-010 Port rstnn_core, output, 1, core-domain reset, active-low.
REQ-011 Port ready, output, 1, high only when both domain resets are released.
REQ-012 Port reset_cause, output, 2, last reset reason: 0 external, 1 lock loss, 2 software.
REQ-013 Port lock_loss_count, output, 8, saturating count of lock-loss events since rstnn.

Function
REQ-014 rstnn SHALL assert the internal reset asynchronously and deassert it synchronously through a SYNC_STAGES flop chain clocked by clk (rstnn_s).
REQ-015 pll_locked SHALL pass through a SYNC_STAGES flop synchronizer (locked_s); locked_s flops SHALL reset to 0.
REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-017 FSM states: ASSERT, WAIT_LOCK, HOLD, REL_PERIPH, RUN.
REQ-018 ASSERT: rstnn_periph=0, rstnn_core=0, ready=0; the FSM SHALL go unconditionally to WAIT_LOCK on the next cycle.
REQ-019 WAIT_LOCK: the counter SHALL increment while locked_s=1 and clear when locked_s=0; after LOCK_STABLE consecutive high cycles the FSM SHALL go to HOLD with the counter cleared.
REQ-020 HOLD: the FSM SHALL remain exactly HOLD_CYCLES cycles, then enter REL_PERIPH, driving rstnn_periph to 1 on that same edge.
REQ-021 REL_PERIPH: the FSM SHALL remain exactly STAGGER_CYCLES cycles, then enter RUN, driving rstnn_core to 1 and ready to 1 on that same edge.
REQ-022 Lock loss: locked_s=0 in HOLD, REL_PERIPH or RUN SHALL move the FSM to ASSERT on the next edge, with both resets and ready going to 0 on that edge, reset_cause=1, and lock_loss_count+1 (saturating at 255).
REQ-023 In RUN, sw_reset_req=1 SHALL move the FSM to ASSERT with reset_cause=2; sw_reset_req SHALL be ignored in every other state.
REQ-024 If lock loss and sw_reset_req occur in the same cycle, lock loss SHALL take priority (reset_cause=1, count incremented).
REQ-025 The shared cycle counter SHALL be wide enough for max(LOCK_STABLE, HOLD_CYCLES, STAGGER_CYCLES) and SHALL never wrap.
REQ-026 Domain release order SHALL always be periph before core; rstnn_core=1 with rstnn_periph=0 SHALL never occur.

Reset
REQ-027 While rstnn_s=0 the block SHALL hold: state ASSERT, counter 0, rstnn_periph 0, rstnn_core 0, ready 0, reset_cause 0, lock_loss_count 0.
REQ-028 Assertion of rstnn in any state SHALL drive rstnn_periph, rstnn_core and ready to 0 asynchronously, without waiting for a clk edge.
REQ-029 reset_cause and lock_loss_count SHALL be cleared only by rstnn and SHALL survive lock-loss and software resets.

Verification (LOCK_STABLE=4, HOLD_CYCLES=8, STAGGER_CYCLES=2, SYNC_STAGES=2)
REQ-030 Power-up with pll_locked held high -> rstnn_periph rises 12 cycles after the first cycle with locked_s=1; rstnn_core and ready rise 2 cycles after that; reset_cause=0.
REQ-031 pll_locked glitches low for 1 cycle after 3 high cycles in WAIT_LOCK -> the counter restarts, and release occurs 12 cycles after the glitch ends.
REQ-032 pll_locked drops in RUN -> all outputs go low 2-3 cycles later; reset_cause=1, lock_loss_count=1; when lock returns, the full sequence repeats.
REQ-033 sw_reset_req pulse in RUN -> resets go low on the next edge, reset_cause=2; the same pulse during HOLD -> no effect.
REQ-034 sw_reset_req and lock loss in the same RUN cycle -> reset_cause=1; 300 lock losses -> lock_loss_count=255.
REQ-035 rstnn asserted mid-HOLD -> outputs go to 0 asynchronously, all registers reach reset values, and the sequence restarts from ASSERT after release.
